min_search_ctrl: RTL and testbench
==================================

// Module: min_search_ctrl
// PURPOSE
//  Sequencer for one shared 13-bit min-tracking register (value + 32-bit tag, strict-less-than update).
//  Per search: clears the register, streams LEN candidates into it via valid/ready, then presents min value+tag.
//  Sits between the SAD/cost pipeline (candidate producer) and the result consumer (best-match logic).
// PARAMETERS
//  VAL_W   13  candidate value width; must match the min register's value width
//  TAG_W   32  candidate tag width (e.g. packed x/y position)
//  LEN_W   16  width of the search-length field; max LEN = 2^LEN_W-1
// PORTS
//  Clk           in   1      clock, all state on rising edge
//  Reset_n       in   1      asynchronous active-low reset
//  start         in   1      begin search; sampled only in IDLE or DONE
//  len           in   LEN_W  candidate count for this search, captured with start
//  abort         in   1      cancel active search, return to IDLE
//  cand_valid    in   1      candidate present
//  cand_ready    out  1      controller accepts candidate this cycle
//  cand_val      in   VAL_W  candidate value
//  cand_tag      in   TAG_W  candidate tag
//  mr_min_in     out  1      to min register: offer in/tag this cycle
//  mr_max_out    out  1      to min register: force stored to all-ones
//  mr_in         out  VAL_W  to min register: value (= cand_val)
//  mr_tag        out  TAG_W  to min register: tag (= cand_tag)
//  mr_smaller    in   1      from min register: mr_in < stored
//  mr_stored     in   VAL_W  from min register: stored value
//  mr_stored_tag in   TAG_W  from min register: stored tag
//  busy          out  1      high in CLEAR and RUN
//  done          out  1      one-cycle pulse on entry to DONE
//  res_valid     out  1      result valid; high throughout DONE
//  res_found     out  1      at least one accepted candidate updated the register
//  res_val       out  VAL_W  = mr_stored while res_valid, else 0
//  res_tag       out  TAG_W  = mr_stored_tag while res_valid, else 0
//  early_out     out  1      search ended by early exit (macro only; else tied 0)
// BEHAVIOUR
//  Reset (async, Reset_n=0): state IDLE; cnt=0, len_q=0; all outputs 0.
//  States: IDLE -> CLEAR -> RUN -> DONE; DONE -> CLEAR on start, DONE -> IDLE on abort.
//  IDLE: start=1 -> capture len_q=len, clear res_found/early_out, go CLEAR.
//  CLEAR (1 cycle): mr_max_out=1, cand_ready=0; next RUN, or DONE directly if len_q==0.
//  RUN: cand_ready=1; accept = cand_valid&cand_ready; mr_min_in=accept; cnt++ per accept.
//   accept with mr_smaller=1 -> res_found<=1.
//   accept with cnt==len_q-1 -> DONE next cycle; cand_ready drops the cycle after the last accept.
//  DONE: done=1 first cycle only; res_valid=1 until next start/abort; register already holds
//   final min (its update completes on the same edge that enters DONE).
//  Ties: strictly-smaller rule -> earliest candidate with the min value wins.
//  All-ones candidate never updates the cleared register: res_found=0, res_val=all-ones.
//  abort in CLEAR/RUN: IDLE next cycle, no done pulse, candidate in that cycle not accepted.
//  abort has priority over start and over last-accept in the same cycle.
//  start in CLEAR/RUN ignored. start in DONE: new search, res_valid drops next cycle.
//  cnt is LEN_W bits and never wraps: terminates at len_q-1 before overflow.
//  Reset mid-search: immediate IDLE; min register contents undefined until next CLEAR.
// CONFIGURATION
//  MIN_SEARCH_EARLY_EXIT_EN defined: in RUN, accept with cand_val==0 -> DONE next cycle,
//   early_out=1 (held with res_valid), remaining candidates not accepted (cand_ready=0).
//  Not defined: zero-valued candidates treated normally; early_out tied 0; all len_q consumed.
// TESTING
//  Reset mid-RUN (len=8, 3 accepted) -> all outputs 0 same cycle, IDLE, no done.
//  len=4, vals 500,120,120,900 tags 1..4 -> done after 4th accept+1, res_val=120, res_tag=2, found=1.
//  len=0 start -> CLEAR one cycle, DONE next, res_found=0, res_val=13'h1FFF.
//  len=5, cand_valid toggled every other cycle -> exactly 5 accepts, min correct, no extra mr_min_in.
//  abort on cycle of 3rd accept of len=3 -> IDLE, no done, start again works with fresh clear.
//  EARLY_EXIT_EN: len=6, vals 40,0,7 -> DONE after 2nd accept, res_val=0, early_out=1, 2 accepts only.

Source files
------------

// File: rtl/min_search_ctrl.sv
// min_search_ctrl: sequences one shared strict-less-than min register
// (value + tag) through clear, streamed candidate offers and result hold.
// Optional feature: define MIN_SEARCH_EARLY_EXIT_EN to end a search as soon
// as a zero-valued candidate is accepted (early_out flags that case).
module min_search_ctrl #(
    parameter int unsigned VAL_W = 13,
    parameter int unsigned TAG_W = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             cand_valid,
    output logic             cand_ready,
    input  logic [VAL_W-1:0] cand_val,
    input  logic [TAG_W-1:0] cand_tag,
    output logic             mr_min_in,
    output logic             mr_max_out,
    output logic [VAL_W-1:0] mr_in,
    output logic [TAG_W-1:0] mr_tag,
    input  logic             mr_smaller,
    input  logic [VAL_W-1:0] mr_stored,
    input  logic [TAG_W-1:0] mr_stored_tag,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    output logic             res_found,
    output logic [VAL_W-1:0] res_val,
    output logic [TAG_W-1:0] res_tag,
    output logic             early_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             found_q, found_d;
    logic             early_q, early_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             res_valid_q, res_valid_d;
    logic             max_out_q, max_out_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             last_accept;
    logic             zero_exit;

    // Abort withdraws ready in the same cycle so the producer never sees a
    // handshake that the controller discards.
    assign cand_ready  = ready_q & ~abort;
    assign accept      = cand_valid & cand_ready;
    assign last_accept = (cnt_q == (len_q - LEN_W'(1)));

`ifdef MIN_SEARCH_EARLY_EXIT_EN
    assign zero_exit = (cand_val == '0);
    assign early_out = early_q;
`else
    assign zero_exit = 1'b0;
    assign early_out = 1'b0;
`endif

    // Min register side: offers only while running, data zeroed otherwise.
    assign mr_min_in  = accept;
    assign mr_max_out = max_out_q;
    assign mr_in      = ready_q ? cand_val : '0;
    assign mr_tag     = ready_q ? cand_tag : '0;

    // Result side: stored value is only presented while the result is valid.
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign res_found = found_q;
    assign res_val   = res_valid_q ? mr_stored : '0;
    assign res_tag   = res_valid_q ? mr_stored_tag : '0;

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        found_d = found_q;
        early_d = early_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    early_d = 1'b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    found_d = 1'b0;
                    state_d = IDLE;
                end else if (accept) begin
                    found_d = found_q | mr_smaller;
                    if (last_accept || zero_exit) begin
                        early_d = zero_exit;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    found_d = 1'b0;
                    early_d = 1'b0;
                    state_d = IDLE;
                end else if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    early_d = 1'b0;
                    state_d = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d == CLEAR) || (state_d == RUN);
        done_d      = (state_d == DONE) && (state_q != DONE);
        res_valid_d = (state_d == DONE);
        max_out_d   = (state_d == CLEAR);
        ready_d     = (state_d == RUN);
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            found_q     <= 1'b0;
            early_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            max_out_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            found_q     <= found_d;
            early_q     <= early_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            max_out_q   <= max_out_d;
            ready_q     <= ready_d;
        end
    end

endmodule

// File: tb/tb_min_search_ctrl.sv
// Directed bench for min_search_ctrl with a behavioural min register model.
module tb_min_search_ctrl;

    localparam int unsigned VAL_W = 13;
    localparam int unsigned TAG_W = 32;
    localparam int unsigned LEN_W = 16;

    logic             Clk, Reset_n, start, abort, cand_valid, cand_ready;
    logic [LEN_W-1:0] len;
    logic [VAL_W-1:0] cand_val, mr_in, mr_stored, res_val;
    logic [TAG_W-1:0] cand_tag, mr_tag, mr_stored_tag, res_tag;
    logic             mr_min_in, mr_max_out, mr_smaller;
    logic             busy, done, res_valid, res_found, early_out;

    int n_vec = 0;
    int n_miss = 0;

    min_search_ctrl #(.VAL_W(VAL_W), .TAG_W(TAG_W), .LEN_W(LEN_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .len(len), .abort(abort),
        .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_val(cand_val), .cand_tag(cand_tag),
        .mr_min_in(mr_min_in), .mr_max_out(mr_max_out), .mr_in(mr_in), .mr_tag(mr_tag),
        .mr_smaller(mr_smaller), .mr_stored(mr_stored), .mr_stored_tag(mr_stored_tag),
        .busy(busy), .done(done), .res_valid(res_valid), .res_found(res_found),
        .res_val(res_val), .res_tag(res_tag), .early_out(early_out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // External min register: clear to all-ones, strict-less-than update.
    assign mr_smaller = (mr_in < mr_stored);
    always @(posedge Clk) begin
        if (mr_max_out) begin
            mr_stored     <= '1;
            mr_stored_tag <= '0;
        end else if (mr_min_in && (mr_in < mr_stored)) begin
            mr_stored     <= mr_in;
            mr_stored_tag <= mr_tag;
        end
    end

    typedef struct packed {
        logic [LEN_W-1:0]      len;
        logic                  alt;
        logic [5:0][VAL_W-1:0] vals;
        logic [TAG_W-1:0]      tbase;
        logic [VAL_W-1:0]      e_val;
        logic [TAG_W-1:0]      e_tag;
        logic                  e_found;
        logic [15:0]           e_acc;
        logic                  e_early;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input int l, input bit alt,
                                input int a, input int b, input int c,
                                input int d, input int e, input int f,
                                input int tb, input int ev, input int et,
                                input bit fd, input int ea, input bit ee);
        vec_t v;
        v.len     = LEN_W'(l);
        v.alt     = alt;
        v.vals[0] = VAL_W'(a);
        v.vals[1] = VAL_W'(b);
        v.vals[2] = VAL_W'(c);
        v.vals[3] = VAL_W'(d);
        v.vals[4] = VAL_W'(e);
        v.vals[5] = VAL_W'(f);
        v.tbase   = TAG_W'(tb);
        v.e_val   = VAL_W'(ev);
        v.e_tag   = TAG_W'(et);
        v.e_found = fd;
        v.e_acc   = 16'(ea);
        v.e_early = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue start with the given length and check the CLEAR cycle.
    task automatic do_start(input int l);
        @(negedge Clk);
        start = 1'b1;
        len   = LEN_W'(l);
        @(negedge Clk);
        start = 1'b0;
        chk("clear_max_out", 32'(mr_max_out), 32'd1);
        chk("clear_ready", 32'(cand_ready), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        chk("clear_res_valid", 32'(res_valid), 32'd0);
    endtask

    // Stream candidates (all-valid) until n accepts have happened.
    task automatic feed_n(input int n, input int base);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 50) begin
            @(negedge Clk);
            cand_valid = 1'b1;
            cand_val   = VAL_W'(base + 10 * acc);
            cand_tag   = TAG_W'(acc);
            #1;
            if (mr_min_in) acc++;
            cyc++;
        end
        @(negedge Clk);
        cand_valid = 1'b0;
        chk("feed_accepts", 32'(acc), 32'(n));
    endtask

    task automatic run_vec(input vec_t v);
        int  acc = 0;
        int  cyc = 0;
        bit  seen = 1'b0;
        do_start(int'(v.len));
        while (!seen && cyc < 100) begin
            @(negedge Clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                cand_valid = (!v.alt || (cyc % 2 == 0)) && (acc < 6);
                cand_val   = (acc < 6) ? v.vals[acc] : '0;
                cand_tag   = v.tbase + TAG_W'(acc);
                #1;
                if (mr_min_in) begin
                    if (mr_in !== cand_val) chk("mr_in_pass", 32'(mr_in), 32'(cand_val));
                    acc++;
                end
                cyc++;
            end
        end
        cand_valid = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("accepts", 32'(acc), 32'(v.e_acc));
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_val", 32'(res_val), 32'(v.e_val));
        chk("res_tag", 32'(res_tag), v.e_tag);
        chk("res_found", 32'(res_found), 32'(v.e_found));
        chk("early_out", 32'(early_out), 32'(v.e_early));
        chk("done_ready", 32'(cand_ready), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        @(negedge Clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("res_valid_hold", 32'(res_valid), 32'd1);
        chk("res_val_hold", 32'(res_val), 32'(v.e_val));
    endtask

    initial begin
        Reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        len        = '0;
        cand_valid = 1'b0;
        cand_val   = '0;
        cand_tag   = '0;

        vecs[0] = mk(4, 1'b0, 500, 120, 120, 900, 0, 0, 1, 120, 2, 1'b1, 4, 1'b0);
        vecs[1] = mk(5, 1'b1, 300, 50, 70, 50, 10, 0, 10, 10, 14, 1'b1, 5, 1'b0);
        vecs[2] = mk(3, 1'b0, 8191, 8191, 8191, 0, 0, 0, 7, 8191, 0, 1'b0, 3, 1'b0);
`ifdef MIN_SEARCH_EARLY_EXIT_EN
        vecs[3] = mk(1, 1'b0, 0, 5, 5, 5, 5, 5, 77, 0, 77, 1'b1, 1, 1'b1);
        vecs[4] = mk(6, 1'b0, 40, 0, 7, 3, 9, 0, 1, 0, 2, 1'b1, 2, 1'b1);
`else
        vecs[3] = mk(1, 1'b0, 0, 5, 5, 5, 5, 5, 77, 0, 77, 1'b1, 1, 1'b0);
        vecs[4] = mk(6, 1'b0, 40, 0, 7, 3, 9, 0, 1, 0, 2, 1'b1, 6, 1'b0);
`endif
        vecs[5] = mk(0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 8191, 0, 1'b0, 0, 1'b0);

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_ready", 32'(cand_ready), 32'd0);
        chk("rst_max_out", 32'(mr_max_out), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Reset in the middle of RUN after three accepts
        do_start(8);
        feed_n(3, 100);
        cand_valid = 1'b1;
        cand_val   = VAL_W'(5);
        Reset_n    = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(cand_ready), 32'd0);
        chk("mid_rst_min_in", 32'(mr_min_in), 32'd0);
        chk("mid_rst_found", 32'(res_found), 32'd0);
        chk("mid_rst_res_val", 32'(res_val), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge Clk);
        Reset_n    = 1'b1;
        cand_valid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("post_rst_idle_busy", 32'(busy), 32'd0);
        chk("post_rst_no_done", 32'(done), 32'd0);

        // Table of complete searches
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Abort on the cycle of the 3rd (last) accept of a len=3 search
        do_start(3);
        feed_n(2, 400);
        cand_valid = 1'b1;
        cand_val   = VAL_W'(1);
        abort      = 1'b1;
        #1;
        chk("abort_ready", 32'(cand_ready), 32'd0);
        chk("abort_min_in", 32'(mr_min_in), 32'd0);
        @(negedge Clk);
        abort      = 1'b0;
        cand_valid = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        @(negedge Clk);
        chk("abort_still_no_done", 32'(done), 32'd0);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
